// File: rtl/operand_stack_ctrl.sv
// WebAssembly operand stack controller: TOS cached in a register,
// deeper entries spilled to a single-port synchronous-read RAM.
module operand_stack_ctrl #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_a,
  output logic [WIDTH-1:0]      rsp_b,
  output logic [DEPTH_BITS-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [DEPTH_BITS:0]   depth,
  output logic [WIDTH-1:0]      result,
  output logic                  result_empty,
  output logic [3:0]            trap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NOS  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;

  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_POP2 = 2'd3;

  localparam logic [DEPTH_BITS:0] D_ZERO = '0;
  localparam logic [DEPTH_BITS:0] D_ONE  = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS:0] D_TWO  = (DEPTH_BITS+1)'(2);
  localparam logic [DEPTH_BITS:0] D_CAP  = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [1:0]            r_state;
  logic [DEPTH_BITS:0]   r_depth;
  logic [WIDTH-1:0]      r_tos;
  logic                  r_rsp_valid;
  logic [WIDTH-1:0]      r_rsp_a;
  logic [WIDTH-1:0]      r_rsp_b;
  logic [3:0]            r_trap;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_pop2;
  logic                  w_ovf;
  logic                  w_unf;
  logic [DEPTH_BITS:0]   w_dm1;
  logic [DEPTH_BITS:0]   w_dm2;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_push    = w_accept & (cmd_op == OP_PUSH);
  assign w_pop     = w_accept & (cmd_op == OP_POP);
  assign w_pop2    = w_accept & (cmd_op == OP_POP2);
  assign w_ovf     = w_push & (r_depth == D_CAP);
  assign w_unf     = (w_pop & (r_depth == D_ZERO))
                   | (w_pop2 & (r_depth < D_TWO));
  assign w_dm1     = r_depth - D_ONE;
  assign w_dm2     = r_depth - D_TWO;

  // After a POP2 the depth already excludes both operands, so in NOS
  // the next-deeper word sits at depth-1.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = r_tos;
    if (w_push && !w_ovf && (r_depth != D_ZERO)) begin
      mem_we   = 1'b1;
      mem_addr = w_dm1[DEPTH_BITS-1:0];
    end else if ((w_pop && (r_depth > D_ONE)) || (w_pop2 && !w_unf)) begin
      mem_re   = 1'b1;
      mem_addr = w_dm2[DEPTH_BITS-1:0];
    end else if ((r_state == S_NOS) && (r_depth != D_ZERO)) begin
      mem_re   = 1'b1;
      mem_addr = w_dm1[DEPTH_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_depth     <= '0;
      r_tos       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_a     <= '0;
      r_rsp_b     <= '0;
      r_trap      <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ovf) begin
            r_state <= S_TRAP;
            r_trap  <= 4'd1;
          end else if (w_unf) begin
            r_state <= S_TRAP;
            r_trap  <= 4'd2;
          end else if (w_push) begin
            r_tos   <= cmd_data;
            r_depth <= r_depth + D_ONE;
          end else if (w_pop) begin
            r_rsp_valid <= 1'b1;
            r_rsp_a     <= r_tos;
            r_rsp_b     <= '0;
            r_depth     <= w_dm1;
            if (r_depth > D_ONE) r_state <= S_FILL;
            else                 r_tos   <= '0;
          end else if (w_pop2) begin
            r_rsp_a <= r_tos;
            r_depth <= w_dm2;
            r_state <= S_NOS;
          end
        end
        S_NOS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_b     <= mem_rdata;
          if (r_depth != D_ZERO) begin
            r_state <= S_FILL;
          end else begin
            r_tos   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_FILL: begin
          r_tos   <= mem_rdata;
          r_state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_a        = r_rsp_a;
  assign rsp_b        = r_rsp_b;
  assign depth        = r_depth;
  assign result       = r_tos;
  assign result_empty = (r_depth == D_ZERO);
  assign trap         = r_trap;

endmodule

// File: tb/tb_operand_stack_ctrl.sv
// Bench for operand_stack_ctrl: directed cases plus random command
// streams checked against a queue-based stack model.
module tb_operand_stack_ctrl;

  localparam int W   = 64;
  localparam int DB  = 2;
  localparam int CAP = 4;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic          rsp_valid;
  logic [W-1:0]  rsp_a;
  logic [W-1:0]  rsp_b;
  logic [DB-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic [DB:0]   depth;
  logic [W-1:0]  result;
  logic          result_empty;
  logic [3:0]    trap;

  operand_stack_ctrl #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .depth(depth), .result(result),
    .result_empty(result_empty), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] ram [0:CAP-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int checks;
  int failures;
  logic [W-1:0] stk[$];
  bit trapped;

  function automatic logic [W-1:0] top_of();
    if (stk.size() == 0) return '0;
    return stk[stk.size()-1];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    step();
    step();
    reset = 1'b0;
    stk.delete();
    trapped = 1'b0;
    chk("rst_depth", 64'(depth), 0);
    chk("rst_result", result, 0);
    chk("rst_empty", 64'(result_empty), 1);
    chk("rst_trap", 64'(trap), 0);
    chk("rst_ready", 64'(cmd_ready), 1);
    chk("rst_rsp", 64'(rsp_valid), 0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data);
    int d;
    int lat;
    int exp_lat;
    logic [3:0] tcode;
    logic [W-1:0] t;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    d = stk.size();
    t = top_of();
    tcode = 4'd0;
    exp_lat = 0;
    ea = '0;
    eb = '0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    #1;
    case (op)
      2'd1: begin
        if (d == CAP) tcode = 4'd1;
        else begin
          chk("push_we", 64'(mem_we), 64'(d > 0));
          if (d > 0) begin
            chk("push_addr", 64'(mem_addr), 64'(d - 1));
            chk("push_wdata", mem_wdata, t);
          end
          stk.push_back(data);
        end
      end
      2'd2: begin
        if (d == 0) tcode = 4'd2;
        else begin
          chk("pop_re", 64'(mem_re), 64'(d > 1));
          if (d > 1) chk("pop_addr", 64'(mem_addr), 64'(d - 2));
          ea = stk.pop_back();
          exp_lat = (d > 1) ? 1 : 0;
        end
      end
      2'd3: begin
        if (d < 2) tcode = 4'd2;
        else begin
          chk("pop2_re", 64'(mem_re), 1);
          chk("pop2_addr", 64'(mem_addr), 64'(d - 2));
          ea = stk.pop_back();
          eb = stk.pop_back();
          exp_lat = (d > 2) ? 1 : 0;
        end
      end
      default: ;
    endcase
    if (tcode != 0) begin
      chk("trap_we", 64'(mem_we), 0);
      chk("trap_re", 64'(mem_re), 0);
    end
    step();
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    if (tcode != 0) begin
      chk("trap_code", 64'(trap), 64'(tcode));
      chk("trap_ready", 64'(cmd_ready), 0);
      chk("trap_depth", 64'(depth), 64'(d));
      chk("trap_result", result, t);
      trapped = 1'b1;
      return;
    end
    if (op == 2'd2) begin
      chk("pop_vld", 64'(rsp_valid), 1);
      chk("pop_a", rsp_a, ea);
      chk("pop_b", rsp_b, 0);
    end else if (op == 2'd3) begin
      chk("pop2_early", 64'(rsp_valid), 0);
      step();
      chk("pop2_vld", 64'(rsp_valid), 1);
      chk("pop2_a", rsp_a, ea);
      chk("pop2_b", rsp_b, eb);
    end else begin
      chk("no_rsp", 64'(rsp_valid), 0);
    end
    lat = 0;
    while (!cmd_ready && lat < 5) begin
      step();
      lat++;
      chk("rsp_pulse", 64'(rsp_valid), 0);
    end
    chk("ready", 64'(cmd_ready), 1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("depth", 64'(depth), 64'(stk.size()));
    chk("result", result, top_of());
    chk("empty", 64'(result_empty), 64'(stk.size() == 0));
    chk("trap_none", 64'(trap), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] v;
    int r;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = '0;
    step();
    do_reset();

    do_cmd(2'd1, 64'd5);
    do_cmd(2'd1, 64'd7);
    do_cmd(2'd3, 64'd0);

    do_reset();
    do_cmd(2'd1, 64'd1);
    do_cmd(2'd1, 64'd2);
    do_cmd(2'd1, 64'd3);
    do_cmd(2'd2, 64'd0);
    chk("t3_result", result, 64'd2);
    chk("t3_depth", 64'(depth), 2);

    do_reset();
    do_cmd(2'd2, 64'd0);
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    cmd_data = 64'hdead;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_ready", 64'(cmd_ready), 0);
      chk("t4_trap", 64'(trap), 2);
      chk("t4_we", 64'(mem_we), 0);
      chk("t4_depth", 64'(depth), 0);
      chk("t4_vld", 64'(rsp_valid), 0);
    end
    cmd_valid = 1'b0;
    do_reset();

    for (int i = 0; i < CAP; i++) begin
      v = {$urandom, $urandom};
      do_cmd(2'd1, v);
    end
    do_cmd(2'd1, 64'h1234);
    chk("t5_trapped", 64'(trapped), 1);
    chk("t5_code", 64'(trap), 1);
    chk("t5_depth", 64'(depth), CAP);
    chk("t5_result", result, v);
    do_reset();

    do_cmd(2'd1, 64'd1);
    do_cmd(2'd1, 64'd2);
    do_cmd(2'd1, 64'd3);
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    step();
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    chk("t6_fill_ready", 64'(cmd_ready), 0);
    reset = 1'b1;
    step();
    chk("t6_depth", 64'(depth), 0);
    chk("t6_vld", 64'(rsp_valid), 0);
    chk("t6_result", result, 0);
    reset = 1'b0;
    chk("t6_ready", 64'(cmd_ready), 1);
    stk.delete();
    trapped = 1'b0;

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      v = {$urandom, $urandom};
      if (r == 0)      do_cmd(2'd0, v);
      else if (r < 5)  do_cmd(2'd1, v);
      else if (r < 8)  do_cmd(2'd2, v);
      else             do_cmd(2'd3, v);
      if (trapped) begin
        step();
        chk("rnd_sticky", 64'(cmd_ready), 0);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
